// File: rtl/digital_lock_seq.sv
// Multi-digit digital lock controller: sequential code entry against a
// reprogrammable stored code, failed-try counting and timed lockout.
module digital_lock_seq #(
  parameter int unsigned DIGIT_W     = 4,
  parameter int unsigned CODE_LEN    = 4,
  parameter int unsigned MAX_TRIES   = 3,
  parameter int unsigned LOCKOUT_CYC = 16,
  parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = '0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic                               prog,
  input  logic                               digit_valid,
  input  logic [DIGIT_W-1:0]                 data_in,
  output logic                               done,
  output logic                               fail,
  output logic                               unlocked,
  output logic                               locked_out,
  output logic                               prog_done,
  output logic [$clog2(MAX_TRIES+1)-1:0]     tries_left
);

  localparam int unsigned IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned CNT_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_OPEN    = 3'd2,
    S_PROG    = 3'd3,
    S_LOCKOUT = 3'd4
  } state_e;

  state_e                             state_q;
  logic [CODE_LEN-1:0][DIGIT_W-1:0]   code_q;
  logic [CODE_LEN-1:0][DIGIT_W-1:0]   shadow_q;
  logic [CODE_LEN-1:0][DIGIT_W-1:0]   shadow_d;
  logic [IDX_W-1:0]                   idx_q;
  logic                               mismatch_q;
  logic [TRY_W-1:0]                   tries_q;
  logic [CNT_W-1:0]                   lock_cnt_q;
  logic                               done_q;
  logic                               fail_q;
  logic                               prog_done_q;
  logic                               unlocked_q;
  logic                               locked_out_q;

  logic                               last_digit_c;
  logic                               miss_c;

  // Running mismatch including the digit currently presented
  always_comb begin
    last_digit_c = (idx_q == IDX_W'(CODE_LEN - 1));
    miss_c       = mismatch_q | (data_in != code_q[idx_q]);
    shadow_d         = shadow_q;
    shadow_d[idx_q]  = data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      code_q       <= DEFAULT_CODE;
      shadow_q     <= '0;
      idx_q        <= '0;
      mismatch_q   <= 1'b0;
      tries_q      <= TRY_W'(MAX_TRIES);
      lock_cnt_q   <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      prog_done_q  <= 1'b0;
      unlocked_q   <= 1'b0;
      locked_out_q <= 1'b0;
    end else begin
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      prog_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_ENTRY;
            idx_q      <= '0;
            mismatch_q <= 1'b0;
          end
        end
        S_ENTRY: begin
          if (start) begin
            idx_q      <= '0;
            mismatch_q <= 1'b0;
          end else if (digit_valid) begin
            if (last_digit_c) begin
              idx_q      <= '0;
              mismatch_q <= 1'b0;
              if (!miss_c) begin
                state_q    <= S_OPEN;
                done_q     <= 1'b1;
                unlocked_q <= 1'b1;
                tries_q    <= TRY_W'(MAX_TRIES);
              end else begin
                fail_q  <= 1'b1;
                tries_q <= tries_q - TRY_W'(1);
                // Last remaining try consumed: go to timed lockout
                if (tries_q == TRY_W'(1)) begin
                  state_q      <= S_LOCKOUT;
                  locked_out_q <= 1'b1;
                  lock_cnt_q   <= CNT_W'(LOCKOUT_CYC - 1);
                end else begin
                  state_q <= S_IDLE;
                end
              end
            end else begin
              idx_q      <= idx_q + IDX_W'(1);
              mismatch_q <= miss_c;
            end
          end
        end
        S_OPEN: begin
          if (prog) begin
            state_q <= S_PROG;
            idx_q   <= '0;
          end else if (start) begin
            state_q    <= S_IDLE;
            unlocked_q <= 1'b0;
          end
        end
        S_PROG: begin
          if (start) begin
            state_q <= S_OPEN;
            idx_q   <= '0;
          end else if (digit_valid) begin
            shadow_q <= shadow_d;
            if (last_digit_c) begin
              code_q      <= shadow_d;
              prog_done_q <= 1'b1;
              state_q     <= S_OPEN;
              idx_q       <= '0;
            end else begin
              idx_q <= idx_q + IDX_W'(1);
            end
          end
        end
        S_LOCKOUT: begin
          if (lock_cnt_q == '0) begin
            state_q      <= S_IDLE;
            locked_out_q <= 1'b0;
            tries_q      <= TRY_W'(MAX_TRIES);
          end else begin
            lock_cnt_q <= lock_cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign done       = done_q;
  assign fail       = fail_q;
  assign prog_done  = prog_done_q;
  assign unlocked   = unlocked_q;
  assign locked_out = locked_out_q;
  assign tries_left = tries_q;

endmodule
